// File: rtl/sirv_spigpioport_pkg.sv
// ============================================================================
// Module   : sirv_spigpioport_pkg
// Brief    : Shared defaults and pad-attribute constants for the SPI GPIO port.
// Revision : 1.0
// ============================================================================
`default_nettype none

package sirv_spigpioport_pkg;

  localparam int DQ_W_DEF       = 4;
  localparam int CS_W_DEF       = 1;
  localparam int SYNC_DEPTH_DEF = 3;
  localparam int FILT_W_DEF     = 3;

  localparam int GLITCH_CNT_W = 8;
  localparam logic [GLITCH_CNT_W-1:0] GLITCH_CNT_MAX = '1;

  localparam logic PAD_PUE_CTRL = 1'b0;
  localparam logic PAD_PUE_DATA = 1'b1;
  localparam logic PAD_DS       = 1'b1;

endpackage

`default_nettype wire

// File: rtl/sirv_spigpio_infilt.sv
// ============================================================================
// Module   : sirv_spigpio_infilt
// Brief    : One data bit: input synchroniser followed by a stability filter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sirv_spigpio_infilt
  import sirv_spigpioport_pkg::*;
#(
  parameter int SYNC_DEPTH = SYNC_DEPTH_DEF,
  parameter int FILT_W     = FILT_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_d,
  input  logic              i_filt_en,
  input  logic [FILT_W-1:0] i_filt_len,
  output logic              o_q,
  output logic              o_reject
);

  logic [SYNC_DEPTH-1:0] r_sync;
  logic                  r_filt;
  logic [FILT_W-1:0]     r_cnt;

  logic                  w_s;
  logic                  w_filt_nxt;
  logic [FILT_W-1:0]     w_cnt_nxt;
  logic                  w_reject;

  assign w_s = r_sync[SYNC_DEPTH-1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_DEPTH-2:0], i_d};
    end
  end

  // While disabled the filter tracks s, so enabling it never causes a jump.
  always_comb begin
    w_filt_nxt = r_filt;
    w_cnt_nxt  = r_cnt;
    w_reject   = 1'b0;
    if (!i_filt_en) begin
      w_filt_nxt = w_s;
      w_cnt_nxt  = '0;
    end else if (w_s == r_filt) begin
      w_cnt_nxt = '0;
      w_reject  = (r_cnt != '0);
    end else if (r_cnt >= i_filt_len) begin
      w_filt_nxt = w_s;
      w_cnt_nxt  = '0;
    end else begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_filt <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_filt <= w_filt_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign o_q      = i_filt_en ? r_filt : w_s;
  assign o_reject = w_reject;

endmodule

`default_nettype wire

// File: rtl/sirv_spigpioport_flex.sv
// ============================================================================
// Module   : sirv_spigpioport_flex
// Brief    : SPI-to-pad port with synchronised, glitch-filtered data inputs.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sirv_spigpioport_flex
  import sirv_spigpioport_pkg::*;
#(
  parameter int DQ_W       = DQ_W_DEF,
  parameter int CS_W       = CS_W_DEF,
  parameter int SYNC_DEPTH = SYNC_DEPTH_DEF,
  parameter int FILT_W     = FILT_W_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    io_spi_sck,
  input  logic [DQ_W-1:0]         io_spi_dq_o,
  input  logic [DQ_W-1:0]         io_spi_dq_oe,
  input  logic [CS_W-1:0]         io_spi_cs,
  output logic [DQ_W-1:0]         io_spi_dq_i,
  input  logic                    cfg_filt_en,
  input  logic [FILT_W-1:0]       cfg_filt_len,
  input  logic                    cfg_loopback,
  input  logic                    cfg_glitch_clr,
  output logic [GLITCH_CNT_W-1:0] stat_glitch_cnt,
  input  logic                    io_pins_sck_i_ival,
  output logic                    io_pins_sck_o_oval,
  output logic                    io_pins_sck_o_oe,
  output logic                    io_pins_sck_o_ie,
  output logic                    io_pins_sck_o_pue,
  output logic                    io_pins_sck_o_ds,
  input  logic [DQ_W-1:0]         io_pins_dq_i_ival,
  output logic [DQ_W-1:0]         io_pins_dq_o_oval,
  output logic [DQ_W-1:0]         io_pins_dq_o_oe,
  output logic [DQ_W-1:0]         io_pins_dq_o_ie,
  output logic [DQ_W-1:0]         io_pins_dq_o_pue,
  output logic [DQ_W-1:0]         io_pins_dq_o_ds,
  input  logic [CS_W-1:0]         io_pins_cs_i_ival,
  output logic [CS_W-1:0]         io_pins_cs_o_oval,
  output logic [CS_W-1:0]         io_pins_cs_o_oe,
  output logic [CS_W-1:0]         io_pins_cs_o_ie,
  output logic [CS_W-1:0]         io_pins_cs_o_pue,
  output logic [CS_W-1:0]         io_pins_cs_o_ds
);

  logic [DQ_W-1:0]         w_src;
  logic [DQ_W-1:0]         w_reject;
  logic                    w_any_reject;
  logic                    w_unused;
  logic [GLITCH_CNT_W-1:0] r_glitch_cnt;

  // SCK and CS pads are output-only; their input values are ignored.
  assign w_unused = &{1'b0, io_pins_sck_i_ival, io_pins_cs_i_ival};

  assign io_pins_sck_o_oval = io_spi_sck;
  assign io_pins_sck_o_oe   = 1'b1;
  assign io_pins_sck_o_ie   = 1'b0;
  assign io_pins_sck_o_pue  = PAD_PUE_CTRL;
  assign io_pins_sck_o_ds   = PAD_DS;

  assign io_pins_cs_o_oval = io_spi_cs;
  assign io_pins_cs_o_oe   = {CS_W{1'b1}};
  assign io_pins_cs_o_ie   = {CS_W{1'b0}};
  assign io_pins_cs_o_pue  = {CS_W{PAD_PUE_CTRL}};
  assign io_pins_cs_o_ds   = {CS_W{PAD_DS}};

  // Loopback isolates the data pads in both directions.
  assign io_pins_dq_o_oval = io_spi_dq_o;
  assign io_pins_dq_o_oe   = io_spi_dq_oe & ~{DQ_W{cfg_loopback}};
  assign io_pins_dq_o_ie   = ~io_spi_dq_oe & ~{DQ_W{cfg_loopback}};
  assign io_pins_dq_o_pue  = {DQ_W{PAD_PUE_DATA}};
  assign io_pins_dq_o_ds   = {DQ_W{PAD_DS}};

  assign w_src = cfg_loopback ? io_spi_dq_o : io_pins_dq_i_ival;

  for (genvar n = 0; n < DQ_W; n++) begin : g_bit
    sirv_spigpio_infilt #(
      .SYNC_DEPTH (SYNC_DEPTH),
      .FILT_W     (FILT_W)
    ) u_infilt (
      .clock      (clock),
      .reset      (reset),
      .i_d        (w_src[n]),
      .i_filt_en  (cfg_filt_en),
      .i_filt_len (cfg_filt_len),
      .o_q        (io_spi_dq_i[n]),
      .o_reject   (w_reject[n])
    );
  end

  assign w_any_reject = |w_reject;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_glitch_cnt <= '0;
    end else if (cfg_glitch_clr) begin
      r_glitch_cnt <= '0;
    end else if (w_any_reject && (r_glitch_cnt != GLITCH_CNT_MAX)) begin
      r_glitch_cnt <= r_glitch_cnt + 1'b1;
    end
  end

  assign stat_glitch_cnt = r_glitch_cnt;

endmodule

`default_nettype wire

// File: tb/tb_sirv_spigpioport_flex.sv
// ============================================================================
// Module   : tb_sirv_spigpioport_flex
// Brief    : Directed and randomised checks against a behavioural port model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sirv_spigpioport_flex;

  localparam int DQ_W = 4;
  localparam int CS_W = 1;
  localparam int SD   = 3;
  localparam int FW   = 3;

  logic            clock = 1'b0;
  logic            reset;
  logic            io_spi_sck;
  logic [DQ_W-1:0] io_spi_dq_o, io_spi_dq_oe, io_spi_dq_i;
  logic [CS_W-1:0] io_spi_cs;
  logic            cfg_filt_en, cfg_loopback, cfg_glitch_clr;
  logic [FW-1:0]   cfg_filt_len;
  logic [7:0]      stat_glitch_cnt;
  logic            io_pins_sck_i_ival;
  logic            sck_oval, sck_oe, sck_ie, sck_pue, sck_ds;
  logic [DQ_W-1:0] io_pins_dq_i_ival;
  logic [DQ_W-1:0] dq_oval, dq_oe, dq_ie, dq_pue, dq_ds;
  logic [CS_W-1:0] io_pins_cs_i_ival;
  logic [CS_W-1:0] cs_oval, cs_oe, cs_ie, cs_pue, cs_ds;

  sirv_spigpioport_flex #(.DQ_W(DQ_W), .CS_W(CS_W), .SYNC_DEPTH(SD), .FILT_W(FW)) dut (
    .clock(clock), .reset(reset),
    .io_spi_sck(io_spi_sck), .io_spi_dq_o(io_spi_dq_o), .io_spi_dq_oe(io_spi_dq_oe),
    .io_spi_cs(io_spi_cs), .io_spi_dq_i(io_spi_dq_i),
    .cfg_filt_en(cfg_filt_en), .cfg_filt_len(cfg_filt_len), .cfg_loopback(cfg_loopback),
    .cfg_glitch_clr(cfg_glitch_clr), .stat_glitch_cnt(stat_glitch_cnt),
    .io_pins_sck_i_ival(io_pins_sck_i_ival),
    .io_pins_sck_o_oval(sck_oval), .io_pins_sck_o_oe(sck_oe), .io_pins_sck_o_ie(sck_ie),
    .io_pins_sck_o_pue(sck_pue), .io_pins_sck_o_ds(sck_ds),
    .io_pins_dq_i_ival(io_pins_dq_i_ival),
    .io_pins_dq_o_oval(dq_oval), .io_pins_dq_o_oe(dq_oe), .io_pins_dq_o_ie(dq_ie),
    .io_pins_dq_o_pue(dq_pue), .io_pins_dq_o_ds(dq_ds),
    .io_pins_cs_i_ival(io_pins_cs_i_ival),
    .io_pins_cs_o_oval(cs_oval), .io_pins_cs_o_oe(cs_oe), .io_pins_cs_o_ie(cs_ie),
    .io_pins_cs_o_pue(cs_pue), .io_pins_cs_o_ds(cs_ds)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: pad history per bit, and per bit the length of the current run of
  // cycles in which the synchronised value has disagreed with the output.
  bit m_hist [DQ_W][SD];
  bit m_out  [DQ_W];
  int m_run  [DQ_W];
  int m_cnt;

  function automatic void model_reset();
    for (int n = 0; n < DQ_W; n++) begin
      for (int k = 0; k < SD; k++) m_hist[n][k] = 1'b0;
      m_out[n] = 1'b0;
      m_run[n] = 0;
    end
    m_cnt = 0;
  endfunction

  function automatic void model_edge(input logic [DQ_W-1:0] src, input bit fen, input int len, input bit clr);
    bit glitch = 1'b0;
    for (int n = 0; n < DQ_W; n++) begin
      bit s = m_hist[n][SD-1];
      if (!fen) begin
        m_out[n] = s; m_run[n] = 0;
      end else if (s != m_out[n]) begin
        // A disagreement that has lasted len+1 cycles is accepted.
        if (m_run[n] + 1 > len) begin m_out[n] = s; m_run[n] = 0; end
        else m_run[n] = m_run[n] + 1;
      end else begin
        if (m_run[n] > 0) glitch = 1'b1;
        m_run[n] = 0;
      end
      for (int k = SD-1; k > 0; k--) m_hist[n][k] = m_hist[n][k-1];
      m_hist[n][0] = src[n];
    end
    if (clr) m_cnt = 0;
    else if (glitch) m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
  endfunction

  function automatic logic [DQ_W-1:0] model_dq();
    logic [DQ_W-1:0] v;
    for (int n = 0; n < DQ_W; n++) v[n] = cfg_filt_en ? m_out[n] : m_hist[n][SD-1];
    return v;
  endfunction

  task automatic check_pads();
    check("sck_pad", {31'd0, sck_oval} << 4 | {27'd0, sck_oe, sck_ie, sck_pue, sck_ds},
          {27'd0, io_spi_sck, 4'b1001});
    check("cs_pad", {22'd0, cs_oval, cs_oe, cs_ie, cs_pue, cs_ds},
          {22'd0, io_spi_cs, {CS_W{1'b1}}, {CS_W{1'b0}}, {CS_W{1'b0}}, {CS_W{1'b1}}});
    check("dq_pad", {12'd0, dq_oval, dq_oe, dq_ie, dq_pue, dq_ds},
          {12'd0, io_spi_dq_o, io_spi_dq_oe & {DQ_W{~cfg_loopback}},
           ~io_spi_dq_oe & {DQ_W{~cfg_loopback}}, {DQ_W{1'b1}}, {DQ_W{1'b1}}});
  endtask

  task automatic step();
    logic [DQ_W-1:0] src;
    bit fen, clr;
    int len;
    src = cfg_loopback ? io_spi_dq_o : io_pins_dq_i_ival;
    fen = cfg_filt_en; clr = cfg_glitch_clr; len = int'(cfg_filt_len);
    @(posedge clock);
    #1;
    model_edge(src, fen, len, clr);
    check("dq_i", {28'd0, io_spi_dq_i}, {28'd0, model_dq()});
    check("glitch_cnt", {24'd0, stat_glitch_cnt}, m_cnt);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_cnt();
    cfg_glitch_clr = 1'b1; step(); cfg_glitch_clr = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    io_spi_sck = 0; io_spi_dq_o = 0; io_spi_dq_oe = 0; io_spi_cs = 0;
    cfg_filt_en = 0; cfg_filt_len = 3'd3; cfg_loopback = 0; cfg_glitch_clr = 0;
    io_pins_sck_i_ival = 0; io_pins_dq_i_ival = 0; io_pins_cs_i_ival = 0;
    model_reset();
    #2;
    check("rst_dq_i", {28'd0, io_spi_dq_i}, 32'd0);
    check("rst_cnt", {24'd0, stat_glitch_cnt}, 32'd0);
    check_pads();
    @(posedge clock); #2; reset = 1'b0;
    steps(4);

    // Filter off: bit 2 appears exactly SD edges after the pad change.
    io_pins_dq_i_ival = 4'b0100;
    steps(2);
    check("nofilt_early", {28'd0, io_spi_dq_i}, 32'd0);
    step();
    check("nofilt_lat3", {28'd0, io_spi_dq_i}, 32'h4);

    // Filter on, L=3: single-cycle pulse is rejected and counted once.
    io_pins_dq_i_ival = 0; cfg_filt_en = 1; cfg_filt_len = 3'd3;
    steps(6); clear_cnt();
    io_pins_dq_i_ival = 4'b0001; step();
    io_pins_dq_i_ival = 4'b0000; steps(8);
    check("pulse_out", {28'd0, io_spi_dq_i}, 32'd0);
    check("pulse_cnt", {24'd0, stat_glitch_cnt}, 32'd1);

    // Filter on, L=3: sustained level passes after SD+L+1 = 7 edges.
    clear_cnt();
    io_pins_dq_i_ival = 4'b0010;
    steps(6);
    check("sust_early", {28'd0, io_spi_dq_i}, 32'd0);
    step();
    check("sust_lat7", {28'd0, io_spi_dq_i}, 32'h2);
    check("sust_cnt", {24'd0, stat_glitch_cnt}, 32'd0);

    // Loopback: pads isolated, data returns from dq_o.
    cfg_filt_en = 0; cfg_loopback = 1; io_spi_dq_oe = 4'hF; io_spi_dq_o = 4'hA;
    io_pins_dq_i_ival = 4'h5;
    #1;
    check("lb_oe", {28'd0, dq_oe}, 32'd0);
    check("lb_ie", {28'd0, dq_ie}, 32'd0);
    steps(3);
    check("lb_dq", {28'd0, io_spi_dq_i}, 32'hA);
    cfg_loopback = 0; io_spi_dq_oe = 0; io_spi_dq_o = 0; io_pins_dq_i_ival = 0;
    steps(4);

    // Saturation at 255, then clear beating a simultaneous increment.
    cfg_filt_en = 1; cfg_filt_len = 3'd3; steps(2); clear_cnt();
    for (int i = 0; i < 262; i++) begin
      io_pins_dq_i_ival = 4'hF; step();
      io_pins_dq_i_ival = 4'h0; step();
    end
    steps(6);
    check("sat_255", {24'd0, stat_glitch_cnt}, 32'd255);
    io_pins_dq_i_ival = 4'hF; step();
    io_pins_dq_i_ival = 4'h0; steps(3);
    cfg_glitch_clr = 1'b1; step(); cfg_glitch_clr = 1'b0;
    check("clr_prio", {24'd0, stat_glitch_cnt}, 32'd0);
    steps(4);

    // Reset mid-filter.
    io_pins_dq_i_ival = 4'b1000; steps(10);
    io_pins_dq_i_ival = 4'b1100; step();
    io_pins_dq_i_ival = 4'b1000; steps(8);
    check("pre_rst_cnt", {24'd0, stat_glitch_cnt}, 32'd1);
    io_pins_dq_i_ival = 4'b1001; steps(5);
    #2; reset = 1'b1; #1;
    model_reset();
    check("mid_rst_dq", {28'd0, io_spi_dq_i}, 32'd0);
    check("mid_rst_cnt", {24'd0, stat_glitch_cnt}, 32'd0);
    @(posedge clock); #2; reset = 1'b0;
    steps(6);
    check("post_rst_early", {28'd0, io_spi_dq_i}, 32'd0);
    step();
    check("post_rst_lat7", {28'd0, io_spi_dq_i}, 32'h9);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      for (int n = 0; n < DQ_W; n++)
        if ($urandom_range(5) == 0) io_pins_dq_i_ival[n] = ~io_pins_dq_i_ival[n];
      if ($urandom_range(49) == 0) cfg_filt_en = ~cfg_filt_en;
      if ($urandom_range(39) == 0) cfg_filt_len = FW'($urandom_range(7));
      if ($urandom_range(59) == 0) cfg_loopback = ~cfg_loopback;
      cfg_glitch_clr = ($urandom_range(99) == 0);
      io_spi_sck = 1'($urandom);
      io_spi_cs = CS_W'($urandom);
      io_spi_dq_oe = DQ_W'($urandom);
      if ($urandom_range(3) == 0) io_spi_dq_o = DQ_W'($urandom);
      io_pins_sck_i_ival = 1'($urandom);
      io_pins_cs_i_ival = CS_W'($urandom);
      #1;
      check_pads();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/sirv_spigpioport_flex.md
SIRV_SPIGPIOPORT_FLEX -- requirements
Module: sirv_spigpioport_flex

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DQ_W, 4, number of SPI data lines (1, 2, 4 or 8).
- CS_W, 1, number of chip selects (1..4).
- SYNC_DEPTH, 3, input synchroniser flops per data line (2..4).
- FILT_W, 3, width of the glitch-filter length field.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning. Reset is reset, asynchronous, active-high; the clock is clock.
- clock  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- io_spi_sck  in  1  SPI master clock.
- io_spi_dq_o  in  DQ_W  data out from the master.
- io_spi_dq_oe  in  DQ_W  data output enables.
- io_spi_cs  in  CS_W  chip selects.
- io_spi_dq_i  out  DQ_W  synchronised, filtered data to the master.
- cfg_filt_en  in  1  glitch filter enable.
- cfg_filt_len  in  FILT_W  filter stability length L.
- cfg_loopback  in  1  internal loopback mode.
- cfg_glitch_clr  in  1  clear the glitch counter.
- stat_glitch_cnt  out  8  saturating count of rejected glitches.
- io_pins_sck_i_ival  in  1  pad input; unused.
- io_pins_sck_o_{oval,oe,ie,pue,ds}  out  1 each  SCK pad controls.
- io_pins_dq_i_ival  in  DQ_W  data pad inputs.
- io_pins_dq_o_{oval,oe,ie,pue,ds}  out  DQ_W each  data pad controls.
- io_pins_cs_i_ival  in  CS_W  pad inputs; unused.
- io_pins_cs_o_{oval,oe,ie,pue,ds}  out  CS_W each  CS pad controls.

Function
REQ-003 The SCK pad SHALL drive: oval=io_spi_sck, oe=1, ie=0, pue=0, ds=1.
REQ-004 Each CS pad bit k SHALL drive: oval=io_spi_cs[k], oe=1, ie=0, pue=0, ds=1.
REQ-005 Each data pad bit n SHALL drive: oval=io_spi_dq_o[n], oe=io_spi_dq_oe[n] & ~cfg_loopback, ie=~io_spi_dq_oe[n] & ~cfg_loopback, pue=1, ds=1; all combinational.
REQ-006 Synchroniser source per bit SHALL be io_pins_dq_i_ival[n]; with cfg_loopback=1 it SHALL instead be io_spi_dq_o[n].
REQ-007 Each bit SHALL pass through SYNC_DEPTH flops; s[n] denotes the last flop.
REQ-008 Each bit SHALL hold a filtered value f[n] and a counter c[n] (FILT_W bits).
REQ-009 When cfg_filt_en=0: io_spi_dq_i[n]=s[n] combinationally; each cycle f[n]<=s[n] and c[n]<=0; latency from pad to output is exactly SYNC_DEPTH edges.
REQ-010 When cfg_filt_en=1: io_spi_dq_i[n]=f[n], updated per cycle as follows.
- s==f and c!=0: c<=0 and a rejection is flagged.
- s==f and c==0: no change.
- s!=f and c>=L: f<=s, c<=0.
- s!=f and c<L: c<=c+1.
REQ-011 Consequently, a level held stable propagates in SYNC_DEPTH+L+1 edges, and a pulse shorter than L+1 cycles at s never reaches io_spi_dq_i.
REQ-012 stat_glitch_cnt SHALL increment by exactly 1 on any cycle where at least one bit flags a rejection, saturating at 255.
REQ-013 cfg_glitch_clr SHALL zero the counter and take priority over a simultaneous increment.
REQ-014 Changing cfg_filt_len mid-count SHALL take effect immediately via the c>=L comparison.
REQ-015 Toggling cfg_filt_en from 0 to 1 SHALL start with f=s and c=0, so no spurious transition occurs.

Reset
REQ-016 On reset, all synchroniser flops, f, c and stat_glitch_cnt SHALL clear to 0, so io_spi_dq_i=0; pad outputs remain combinational per REQ-003..005.

Structure
REQ-017 Package sirv_spigpioport_pkg SHALL hold the parameter defaults, the pad-attribute constants (PUE/DS values) and the glitch counter width (8).
REQ-018 Sub-module sirv_spigpio_infilt SHALL implement one bit of synchroniser plus filter and a rejection flag; it is instantiated DQ_W times, with the OR-reduced flags and the counter at top level.

Verification
REQ-019 The bench SHALL cover the following directed scenarios (defaults unless stated).
- Filter off, pad dq[2] 0->1 -> io_spi_dq_i[2]=1 exactly 3 edges later; other bits stay 0.
- Filter on, L=3, 1-cycle high pulse on dq[0] -> output stays 0; stat_glitch_cnt=1.
- Filter on, L=3, sustained high on dq[1] -> output rises 7 edges after the pad change; counter unchanged.
- Loopback=1, dq_oe=4'hF, dq_o=4'hA -> pad oe=0, ie=0; io_spi_dq_i=4'hA after 3 edges, regardless of pad ival.
- Counter at 255 with a further glitch -> holds 255; glitch plus cfg_glitch_clr in the same cycle -> 0.
- Reset asserted mid-filter (c=2) -> io_spi_dq_i=0 and counter=0 immediately; after release, normal latency resumes.
